// File: rtl/sram_bus_target_if.sv
// sram_bus_target_if: multiplexed-address SRAM bus between an initiator and a responder.
//   sram_cen      chip enable, active-low
//   sram_ale      2'b10 = address high byte, 2'b01 = address low byte + adrh
//   sram_rdn      read strobe, active-low
//   sram_wdn      write strobe, active-low
//   sram_adrh     high address bits, valid in the ALE=01 cycle
//   sram_wda      initiator-driven bus: address bytes, then write data
//   sram_bus_oen  1 = initiator has released the bus for a read
//   sram_rd       read data returned by the responder
//   sram_rd_oe    drive enable for sram_rd
// Modports: master = initiator side, slave = responder side.
interface sram_bus_target_if #(
    parameter int unsigned ADRH_W = 4
);
    logic              sram_cen;
    logic [1:0]        sram_ale;
    logic              sram_rdn;
    logic              sram_wdn;
    logic [ADRH_W-1:0] sram_adrh;
    logic [7:0]        sram_wda;
    logic              sram_bus_oen;
    logic [7:0]        sram_rd;
    logic              sram_rd_oe;

    modport master (
        output sram_cen, sram_ale, sram_rdn, sram_wdn, sram_adrh, sram_wda, sram_bus_oen,
        input  sram_rd, sram_rd_oe
    );

    modport slave (
        input  sram_cen, sram_ale, sram_rdn, sram_wdn, sram_adrh, sram_wda, sram_bus_oen,
        output sram_rd, sram_rd_oe
    );
endinterface

// File: rtl/sram_bus_target.sv
// sram_bus_target: responder end of the multiplexed-address SRAM bus. Decodes the two ALE
// address phases, then services one read or write strobe against a synchronous memory with
// one cycle of read latency.
// Ports:
//   clock, reset_n   clock and synchronous active-low reset
//   bus              SRAM bus (slave modport)
//   mem_addr         backing memory address {adrh, hi, lo}
//   mem_rd_en        backing memory read request, data on mem_rdata next cycle
//   mem_wr_en        backing memory write strobe
//   mem_wd           backing memory write data
//   mem_rdata        backing memory read data
//   rd_count         completed reads (wraps)
//   wr_count         completed writes (wraps)
//   proto_err        sticky protocol-violation flag
module sram_bus_target #(
    parameter int unsigned ADRH_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    sram_bus_target_if.slave    bus,
    output logic [ADRH_W+15:0]  mem_addr,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    output logic [7:0]          mem_wd,
    input  logic [7:0]          mem_rdata,
    output logic [CNT_W-1:0]    rd_count,
    output logic [CNT_W-1:0]    wr_count,
    output logic                proto_err
);

    typedef enum logic [1:0] {StIdle, StHi, StLo, StDone} state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [7:0]          r_hi_lat;
    logic [7:0]          r_lo_lat;
    logic [ADRH_W-1:0]   r_adrh_lat;
    logic [7:0]          r_rd_hold;
    logic [CNT_W-1:0]    r_rd_count;
    logic [CNT_W-1:0]    r_wr_count;
    logic                r_proto_err;

    logic w_hi_ld;
    logic w_prefetch;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_err_set;
    logic w_strobe;

    assign w_strobe = !bus.sram_rdn || !bus.sram_wdn;

    always_comb begin
        w_state_nxt = r_state;
        w_hi_ld     = 1'b0;
        w_prefetch  = 1'b0;
        w_rd_acc    = 1'b0;
        w_wr_acc    = 1'b0;
        w_err_set   = 1'b0;
        if (bus.sram_cen) begin
            w_state_nxt = StIdle;
        end else begin
            // A strobe before the address is complete is a violation; in DONE a strobe
            // still held over from the serviced access is simply ignored.
            if (w_strobe && (r_state == StIdle || r_state == StHi)) begin
                w_err_set = 1'b1;
            end
            if (bus.sram_ale == 2'b10) begin
                w_hi_ld     = 1'b1;
                w_state_nxt = StHi;
            end else if (bus.sram_ale == 2'b11) begin
                w_err_set   = 1'b1;
                w_state_nxt = StIdle;
            end else begin
                unique case (r_state)
                    StIdle: ;
                    StHi: begin
                        if (bus.sram_ale == 2'b01) begin
                            // Read speculatively so data is ready in the strobe cycle.
                            w_prefetch  = 1'b1;
                            w_state_nxt = StLo;
                        end else begin
                            w_err_set   = 1'b1;
                            w_state_nxt = StIdle;
                        end
                    end
                    StLo: begin
                        w_state_nxt = StDone;
                        unique case ({bus.sram_rdn, bus.sram_wdn})
                            2'b01:   w_rd_acc  = 1'b1;
                            2'b10:   w_wr_acc  = 1'b1;
                            2'b00:   w_err_set = 1'b1;
                            default: ;
                        endcase
                    end
                    StDone: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_hi_lat    <= '0;
            r_lo_lat    <= '0;
            r_adrh_lat  <= '0;
            r_rd_hold   <= '0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hi_ld) begin
                r_hi_lat <= bus.sram_wda;
            end
            if (w_prefetch) begin
                r_lo_lat   <= bus.sram_wda;
                r_adrh_lat <= bus.sram_adrh;
            end
            if (w_rd_acc) begin
                r_rd_hold  <= mem_rdata;
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
            if (w_wr_acc) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        if (w_prefetch) begin
            mem_addr = {bus.sram_adrh, r_hi_lat, bus.sram_wda};
        end else begin
            mem_addr = {r_adrh_lat, r_hi_lat, r_lo_lat};
        end
    end

    // Reset gates the strobes combinationally so a write in flight is dropped.
    assign mem_rd_en      = w_prefetch && reset_n;
    assign mem_wr_en      = w_wr_acc && reset_n;
    assign mem_wd         = bus.sram_wda;
    assign bus.sram_rd    = (r_state == StLo && !bus.sram_rdn) ? mem_rdata : r_rd_hold;
    assign bus.sram_rd_oe = bus.sram_bus_oen && !bus.sram_rdn && !bus.sram_cen && reset_n;
    assign rd_count       = r_rd_count;
    assign wr_count       = r_wr_count;
    assign proto_err      = r_proto_err;

endmodule

// File: tb/tb_sram_bus_target.sv
// tb_sram_bus_target: randomized scoreboard bench for sram_bus_target. A behavioural byte
// memory predicts read data and write traffic; a negedge monitor pops expectations whenever
// the target drives read data or strobes the backing memory.
module tb_sram_bus_target;

    localparam int unsigned ADRH_W = 4;
    localparam int unsigned CNT_W  = 8;   // narrow counter so the wrap is reachable quickly
    localparam int unsigned AW     = ADRH_W + 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [AW-1:0]     mem_addr;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [7:0]        mem_wd;
    logic [7:0]        mem_rdata = 8'h00;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  wr_count;
    logic              proto_err;

    sram_bus_target_if #(.ADRH_W(ADRH_W)) bus ();

    sram_bus_target #(.ADRH_W(ADRH_W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_wd    (mem_wd),
        .mem_rdata (mem_rdata),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .proto_err (proto_err)
    );

    always #5 clock = ~clock;

    // Backing synchronous memory (environment, not the reference).
    logic [7:0] bmem [int unsigned];
    always @(posedge clock) begin
        if (mem_wr_en) bmem[32'(mem_addr)] = mem_wd;
        if (mem_rd_en) mem_rdata <= bmem.exists(32'(mem_addr)) ? bmem[32'(mem_addr)] : 8'h00;
    end

    // Reference model: plain byte array plus access counts.
    logic [7:0] rmem [int unsigned];
    int unsigned exp_rd = 0;
    int unsigned exp_wr = 0;

    function automatic logic [7:0] ref_read(input logic [AW-1:0] a);
        return rmem.exists(32'(a)) ? rmem[32'(a)] : 8'h00;
    endfunction

    logic [7:0]         rdq [$];
    logic [AW+7:0]      wrq [$];
    int n_vec = 0;
    int n_bad = 0;
    int n_wr_pulse = 0;
    int n_rd_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: compares whenever the target presents read data or writes memory.
    always @(negedge clock) begin
        logic [7:0]    er;
        logic [AW+7:0] ew;
        if (mem_rd_en) n_rd_en++;
        if (bus.sram_rd_oe) begin
            n_vec++;
            if (rdq.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read", bus.sram_rd);
            end else begin
                er = rdq.pop_front();
                if (bus.sram_rd !== er) begin
                    n_bad++;
                    $display("FAIL rd_data: got 0x%0h expected 0x%0h", bus.sram_rd, er);
                end
            end
        end
        if (mem_wr_en) begin
            n_wr_pulse++;
            n_vec++;
            if (wrq.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write",
                         mem_addr, mem_wd);
            end else begin
                ew = wrq.pop_front();
                if ({mem_addr, mem_wd} !== ew) begin
                    n_bad++;
                    $display("FAIL wr_op: got 0x%0h expected 0x%0h", {mem_addr, mem_wd}, ew);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        bus.sram_cen     = 1'b1;
        bus.sram_ale     = 2'b00;
        bus.sram_rdn     = 1'b1;
        bus.sram_wdn     = 1'b1;
        bus.sram_adrh    = '0;
        bus.sram_wda     = 8'h00;
        bus.sram_bus_oen = 1'b0;
    endtask

    task automatic addr_phases(input logic [AW-1:0] a);
        bus.sram_cen  = 1'b0;
        bus.sram_rdn  = 1'b1;
        bus.sram_wdn  = 1'b1;
        bus.sram_ale  = 2'b10;
        bus.sram_wda  = a[15:8];
        cyc();
        bus.sram_ale  = 2'b01;
        bus.sram_wda  = a[7:0];
        bus.sram_adrh = a[AW-1:16];
        cyc();
        bus.sram_ale  = 2'b00;
    endtask

    // Leaves the target in DONE with cen still low.
    task automatic do_read(input logic [AW-1:0] a);
        addr_phases(a);
        bus.sram_rdn     = 1'b0;
        bus.sram_bus_oen = 1'b1;
        rdq.push_back(ref_read(a));
        exp_rd++;
        cyc();
        bus.sram_rdn     = 1'b1;
        bus.sram_bus_oen = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
        addr_phases(a);
        bus.sram_wdn = 1'b0;
        bus.sram_wda = d;
        wrq.push_back({a, d});
        rmem[32'(a)] = d;
        exp_wr++;
        cyc();
        bus.sram_wdn = 1'b1;
    endtask

    task automatic gap(input int n);
        bus_idle();
        repeat (n) cyc();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int r0;
        logic [AW-1:0] a;
        bus_idle();
        reset_n = 1'b0;
        repeat (3) cyc();
        chk("reset_rd_count", 32'(rd_count), 0);
        chk("reset_wr_count", 32'(wr_count), 0);
        chk("reset_proto_err", 32'(proto_err), 0);
        chk("reset_rd_en", 32'(mem_rd_en), 0);
        reset_n = 1'b1;
        cyc();

        // Read of a preloaded location.
        bmem[32'h3_1234] = 8'hA5;
        rmem[32'h3_1234] = 8'hA5;
        do_read(20'h3_1234);
        chk("rd_hold", 32'(bus.sram_rd), 32'hA5);
        chk("rd_count_1", 32'(rd_count), 1);
        gap(1);

        // Write to the top address, then read it back.
        p0 = n_wr_pulse;
        do_write(20'hF_FFFF, 8'h5C);
        gap(2);
        chk("wr_pulse_once", 32'(n_wr_pulse - p0), 1);
        chk("wr_count_1", 32'(wr_count), 1);
        do_read(20'hF_FFFF);
        gap(1);

        // Random mix over a small address pool; chained or separated by cen high.
        for (int i = 0; i < 300; i++) begin
            a = AW'(($urandom_range(0, 15) << 16) | $urandom_range(0, 47));
            if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
            else do_read(a);
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
        end
        gap(1);
        chk("rand_rd_count", 32'(rd_count), exp_rd % (1 << CNT_W));
        chk("rand_wr_count", 32'(wr_count), exp_wr % (1 << CNT_W));
        chk("rand_proto_err", 32'(proto_err), 0);

        // Abort after the high address byte: no memory traffic, no error.
        p0 = n_wr_pulse;
        r0 = n_rd_en;
        bus.sram_cen = 1'b0;
        bus.sram_ale = 2'b10;
        bus.sram_wda = 8'h42;
        cyc();
        gap(3);
        chk("abort_rd_en", 32'(n_rd_en - r0), 0);
        chk("abort_wr_en", 32'(n_wr_pulse - p0), 0);
        chk("abort_proto_err", 32'(proto_err), 0);
        do_read(20'h3_1234);
        gap(1);

        // Back-to-back writes from DONE up to the counter wrap.
        while ((exp_wr % (1 << CNT_W)) != (1 << CNT_W) - 1) begin
            do_write(AW'($urandom_range(0, 255)), 8'($urandom));
        end
        chk("wr_count_max", 32'(wr_count), (1 << CNT_W) - 1);
        do_write(20'h0_0010, 8'h3C);
        chk("wr_count_wrap", 32'(wr_count), 0);
        do_read(20'h0_0010);
        gap(1);
        chk("chain_rd_count", 32'(rd_count), exp_rd % (1 << CNT_W));

        // Both strobes together in LO.
        p0 = n_wr_pulse;
        addr_phases(20'h1_2345);
        bus.sram_rdn = 1'b0;
        bus.sram_wdn = 1'b0;
        cyc();
        gap(1);
        chk("both_wr_en", 32'(n_wr_pulse - p0), 0);
        chk("both_proto_err", 32'(proto_err), 1);
        chk("both_rd_count", 32'(rd_count), exp_rd % (1 << CNT_W));
        chk("both_wr_count", 32'(wr_count), exp_wr % (1 << CNT_W));

        // Reset during a write strobe drops the write.
        addr_phases(20'h2_0033);
        bus.sram_wdn = 1'b0;
        bus.sram_wda = 8'h77;
        reset_n      = 1'b0;
        @(negedge clock);
        chk("rst_wr_en", 32'(mem_wr_en), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        bus_idle();
        exp_rd = 0;
        exp_wr = 0;
        chk("rst_rd_count", 32'(rd_count), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        cyc();
        do_read(20'h2_0033);
        gap(2);
        chk("post_rst_rd_count", 32'(rd_count), 1);
        chk("rdq_drained", 32'(rdq.size()), 0);
        chk("wrq_drained", 32'(wrq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
